pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. It generates PC enable and the per-register stall/flush controls, including the IF/ID register's `stall` and `flush` inputs. It resolves load-use hazards, EX-stage redirects (taken branch/jump), instruction-fetch latency and multi-cycle data-memory waits. It also keeps saturating performance counters and a memory-wait watchdog.

## Interface
- `REG_AW`, 5: register-address width.
- `CNT_W`, 32: width of the performance counters.
- `MEM_TIMEOUT`, 255: number of consecutive data-memory wait cycles before `mem_timeout` is set.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in REG_AW: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads that source.
- `ex_rd` in REG_AW: destination register of the instruction in EX.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_redirect` in 1: branch/jump in EX is taken; PC mux selects the target this cycle.
- `mem_req` in 1: MEM stage is performing a data access.
- `mem_ready` in 1: data access completes this cycle.
- `imem_ready` in 1: fetch data for the current PC is valid. Instruction memory holds it until the PC changes.
- `pc_en` out 1: PC register loads the next PC.
- `if_id_stall`, `if_id_flush` out 1: IF/ID hold / insert bubble.
- `id_ex_stall`, `id_ex_flush` out 1: ID/EX hold / insert bubble.
- `ex_mem_stall` out 1: EX/MEM hold.
- `mem_wb_flush` out 1: MEM/WB insert bubble.
- `stall_count` out CNT_W: cycles with `pc_en`=0 outside reset.
- `flush_count` out CNT_W: accepted redirects.
- `mem_timeout` out 1: sticky watchdog flag.

## Operation
- Derived terms:
  - `mem_stall` = `mem_req` & !`mem_ready`.
  - `load_use` = `ex_mem_read` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Control outputs are Mealy: combinational from state and inputs. Default is `pc_en`=1 and all stall/flush signals 0.
- FSM states: RUN, MEM_WAIT, REFILL.
- Evaluation priority is identical in every state; the first matching rule wins:
  1. `mem_stall`: freeze. `pc_en`=0; `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_flush`=1. Next state is MEM_WAIT. A redirect or load-use condition present in the same cycle is held by the freeze and re-evaluated later.
  2. `ex_redirect`: `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1, `flush_count`+1. Next state is REFILL.
  3. `load_use`: `pc_en`=0, `if_id_stall`=1, `id_ex_flush`=1 (exactly one bubble). State unchanged, or RUN if in MEM_WAIT.
  4. `imem` not ready: `pc_en`=0, `if_id_flush`=1. Next state: REFILL stays REFILL; otherwise RUN.
  5. Otherwise: defaults. Next state is RUN.
- Meaning of the states:
  - MEM_WAIT marks an ongoing data-memory wait.
  - REFILL marks fetch from a redirect target. It exits to RUN on the first cycle `imem_ready`=1 with no higher-priority rule active.
- Watchdog: `wait_cnt` (width clog2(MEM_TIMEOUT+1)) increments on every `mem_stall` cycle and clears otherwise. When `wait_cnt`==MEM_TIMEOUT while `mem_stall`, `mem_timeout` is set and stays set until `rst`. The pipeline stays frozen; there is no forced release.
- Both counters saturate at all-ones and never wrap. `stall_count` increments every non-reset cycle with `pc_en`=0.

## Timing
- While `rst`=1:
  - State is RUN; `wait_cnt`, both counters and `mem_timeout` are 0.
  - All control outputs are forced to 0, including `pc_en`. Pipeline registers reset themselves.
- Zero-cycle latency from inputs to control outputs. State, counters and flag update on the `clk` edge.
- Load-use costs exactly 1 cycle. A redirect costs 2 bubbles plus REFILL wait cycles.
- A `mem_ready` cycle releases the freeze in that same cycle.
- `rst` asserted mid-MEM_WAIT or mid-REFILL goes to RUN on the next edge. No residual stall.

## Structure
- `pipe_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (RUN, MEM_WAIT, REFILL);
  - `REG_AW_DEF`;
  - a `ctrl_bus_t` packed struct grouping the seven control outputs.
- Sub-module `sat_counter` (parameter W; inputs `inc` and `rst`; output `count`) is instantiated twice, for `stall_count` and `flush_count`.

## Test plan
- Load x5 in EX, ID reads rs2=5 with `id_use_rs2`=1 → 1 cycle with `pc_en`=0, `if_id_stall`=1, `id_ex_flush`=1. With `ex_rd`=0 → no stall.
- `ex_redirect` pulse, `imem_ready` low for 3 cycles → `if_id_flush`=1, `id_ex_flush`=1 in the redirect cycle. Then 3 REFILL cycles with `if_id_flush`=1 and `pc_en`=0. `flush_count`=1, `stall_count`=3.
- `mem_req`=1, `mem_ready` low 4 cycles then high → 4 freeze cycles with `mem_wb_flush`=1. Release in the 5th cycle.
- `mem_stall` together with `ex_redirect` and `load_use` → freeze only. The redirect is taken on the `mem_ready` cycle.
- MEM_TIMEOUT=3, `mem_req` held with `mem_ready` low → `mem_timeout` rises after the 4th stall cycle and stays high until `rst`.
- Preset `stall_count` to near max (CNT_W=4), 20 stall cycles → holds at 15. `rst` asserted during REFILL → RUN and all counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REFILL   = 2'd2
  } ctrl_state_t;

  // Per-cycle pipeline control word
  typedef struct packed {
    logic pc_en;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_bus_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use,
// EX redirects, fetch latency, data-memory waits, perf counters, watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              imem_ready,
  output logic              pc_en,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              mem_timeout
);

  localparam int unsigned WAIT_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WAIT_W   = (WAIT_RAW < 1) ? 1 : WAIT_RAW;

  ctrl_state_t       state, state_nxt;
  ctrl_bus_t         ctrl, ctrl_out;
  logic              mem_stall;
  logic              load_use;
  logic              redirect_take;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_hit;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
  assign wait_hit  = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Prioritised hazard resolution: next state and control word
  always_comb begin
    state_nxt     = RUN;
    ctrl          = '0;
    ctrl.pc_en    = 1'b1;
    redirect_take = 1'b0;
    if (mem_stall) begin
      ctrl.pc_en        = 1'b0;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
      state_nxt         = MEM_WAIT;
    end else if (ex_redirect) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      redirect_take    = 1'b1;
      state_nxt        = REFILL;
    end else if (load_use) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      state_nxt        = (state == MEM_WAIT) ? RUN : state;
    end else if (!imem_ready) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_flush = 1'b1;
      state_nxt        = (state == REFILL) ? REFILL : RUN;
    end
  end

  // All controls low while in reset
  assign ctrl_out     = rst ? '0 : ctrl;
  assign pc_en        = ctrl_out.pc_en;
  assign if_id_stall  = ctrl_out.if_id_stall;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_stall  = ctrl_out.id_ex_stall;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_mem_stall = ctrl_out.ex_mem_stall;
  assign mem_wb_flush = ctrl_out.mem_wb_flush;

  // Consecutive memory-wait counter, held at the threshold so it cannot wrap
  always_ff @(posedge clk) begin
    if (rst || !mem_stall) wait_cnt <= '0;
    else if (!wait_hit)    wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst)                       mem_timeout <= 1'b0;
    else if (mem_stall && wait_hit) mem_timeout <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~rst & ~ctrl.pc_en),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~rst & redirect_take),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (narrow counters, short watchdog).
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MEM_TO = 3;

  // {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] C_RST    = 7'b0000000;
  localparam logic [6:0] C_DEF    = 7'b1000000;
  localparam logic [6:0] C_FREEZE = 7'b0101011;
  localparam logic [6:0] C_REDIR  = 7'b1010100;
  localparam logic [6:0] C_LU     = 7'b0100100;
  localparam logic [6:0] C_IMISS  = 7'b0010000;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic              mem_req, mem_ready, imem_ready;
  logic              pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic              ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [CNT_W-1:0]  stall_count, flush_count;
  logic [6:0]        obs;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_flush};

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .imem_ready(imem_ready),
    .pc_en(pc_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if (obs !== C_RST) begin nerr++; $display("FAIL reset_ctrl got=%b exp=%b", obs, C_RST); end
    nvec++; if (stall_count !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
      nerr++; $display("FAIL reset_regs got stall=%0d flush=%0d to=%b exp 0/0/0", stall_count, flush_count, mem_timeout);
    end
    rst = 1'b0;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL reset_release got=%b exp=%b", obs, C_DEF); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    #1;
    nvec++; if (obs !== C_LU) begin nerr++; $display("FAIL load_use_rs2 got=%b exp=%b", obs, C_LU); end
    tick();
    ex_mem_read = 1'b0;  // load moved on, bubble now in EX
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL load_use_after got=%b exp=%b", obs, C_DEF); end
    nvec++; if (stall_count !== 4'd1) begin nerr++; $display("FAIL load_use_cost got=%0d exp=1", stall_count); end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs1 = 5'd0;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL load_use_x0 got=%b exp=%b", obs, C_DEF); end
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd9;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL load_use_unused got=%b exp=%b", obs, C_DEF); end
    id_use_rs1 = 1'b1;
    #1;
    nvec++; if (obs !== C_LU) begin nerr++; $display("FAIL load_use_rs1 got=%b exp=%b", obs, C_LU); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1'b1; imem_ready = 1'b0;
    #1;
    nvec++; if (obs !== C_REDIR) begin nerr++; $display("FAIL redirect_cycle got=%b exp=%b", obs, C_REDIR); end
    tick();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (obs !== C_IMISS) begin nerr++; $display("FAIL refill_%0d got=%b exp=%b", i, obs, C_IMISS); end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL refill_exit got=%b exp=%b", obs, C_DEF); end
    tick();
    nvec++; if (flush_count !== 4'd1 || stall_count !== 4'd3) begin
      nerr++; $display("FAIL redirect_counts got flush=%0d stall=%0d exp 1/3", flush_count, stall_count);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if (obs !== C_FREEZE) begin nerr++; $display("FAIL mem_freeze_%0d got=%b exp=%b", i, obs, C_FREEZE); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL mem_release got=%b exp=%b", obs, C_DEF); end
    tick();
    mem_req = 1'b0;
    nvec++; if (stall_count !== 4'd4) begin nerr++; $display("FAIL mem_stall_count got=%0d exp=4", stall_count); end
  endtask

  task automatic test_priority();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++; if (obs !== C_FREEZE) begin nerr++; $display("FAIL prio_freeze_%0d got=%b exp=%b", i, obs, C_FREEZE); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    nvec++; if (obs !== C_REDIR) begin nerr++; $display("FAIL prio_redirect got=%b exp=%b", obs, C_REDIR); end
    tick();
    nvec++; if (flush_count !== 4'd1 || stall_count !== 4'd2) begin
      nerr++; $display("FAIL prio_counts got flush=%0d stall=%0d exp 1/2", flush_count, stall_count);
    end
    // freeze with load-use only, then load-use resolves on release
    ex_redirect = 1'b0; mem_ready = 1'b0;
    #1;
    nvec++; if (obs !== C_FREEZE) begin nerr++; $display("FAIL prio_lu_freeze got=%b exp=%b", obs, C_FREEZE); end
    tick();
    mem_ready = 1'b1;
    #1;
    nvec++; if (obs !== C_LU) begin nerr++; $display("FAIL prio_lu_release got=%b exp=%b", obs, C_LU); end
    tick();
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    nvec++; if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL wd_3cyc got=%b exp=0", mem_timeout); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    nvec++; if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL wd_restart got=%b exp=0", mem_timeout); end
    tick();
    nvec++; if (mem_timeout !== 1'b1) begin nerr++; $display("FAIL wd_4cyc got=%b exp=1", mem_timeout); end
    #1;
    nvec++; if (obs !== C_FREEZE) begin nerr++; $display("FAIL wd_frozen got=%b exp=%b", obs, C_FREEZE); end
    idle();
    for (int i = 0; i < 3; i++) tick();
    nvec++; if (mem_timeout !== 1'b1) begin nerr++; $display("FAIL wd_sticky got=%b exp=1", mem_timeout); end
    do_reset();
    nvec++; if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL wd_reset got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_saturate();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    nvec++; if (stall_count !== 4'd14) begin nerr++; $display("FAIL sat_14 got=%0d exp=14", stall_count); end
    for (int i = 0; i < 6; i++) tick();
    nvec++; if (stall_count !== 4'd15) begin nerr++; $display("FAIL sat_hold got=%0d exp=15", stall_count); end
    idle();
  endtask

  task automatic test_reset_refill();
    do_reset();
    ex_redirect = 1'b1; imem_ready = 1'b0;
    tick();
    ex_redirect = 1'b0;
    tick();
    nvec++; if (flush_count !== 4'd1 || stall_count !== 4'd1) begin
      nerr++; $display("FAIL rr_pre got flush=%0d stall=%0d exp 1/1", flush_count, stall_count);
    end
    rst = 1'b1;
    #1;
    nvec++; if (obs !== C_RST) begin nerr++; $display("FAIL rr_ctrl got=%b exp=%b", obs, C_RST); end
    tick();
    nvec++; if (flush_count !== 4'd0 || stall_count !== 4'd0) begin
      nerr++; $display("FAIL rr_counts got flush=%0d stall=%0d exp 0/0", flush_count, stall_count);
    end
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    nvec++; if (obs !== C_DEF) begin nerr++; $display("FAIL rr_run got=%b exp=%b", obs, C_DEF); end
    tick();
    nvec++; if (stall_count !== 4'd0) begin nerr++; $display("FAIL rr_no_residual got=%0d exp=0", stall_count); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_priority();
    test_timeout();
    test_saturate();
    test_reset_refill();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
